// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding, datapath constants and operand-signedness helpers.
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [2:0] f3);
        case (f3)
            F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // rs2 is treated as signed for MUL, MULH, DIV and REM
    function automatic logic b_is_signed(input logic [2:0] f3);
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement. Used both to turn signed operands into
// magnitudes and to restore the sign of the final product/quotient/remainder.
// Negating INT_MIN yields INT_MIN again, which read as unsigned is the
// correct magnitude 2^31, so no extra bit is needed on the output.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    // negate when requested, otherwise pass through
    always_comb begin
        res = val;
        if (neg) begin
            res = ~val + {{(W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Radix-2 multi-cycle RV32M multiply/divide sequencer (IDLE -> CALC -> FIN).
// One product/quotient bit per cycle on operand magnitudes; signs restored in FIN.
// Optional build macro MDU_FAST_ZERO_EN: zero operands short-circuit to FIN.
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import mdu_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        f3_r;
    logic [XLEN-1:0]   div_r;        // magnitude of op_b (multiplicand / divisor)
    logic [2*XLEN-1:0] acc_r;        // {hi, lo}: product, or {remainder, quotient}
    logic              neg_res_r;    // sign of product / quotient
    logic              neg_rem_r;    // sign of remainder
    logic              special_r;    // acc_r[XLEN-1:0] already holds the final value
    logic [XLEN-1:0]   result_r;

    logic              sign_a_s;
    logic              sign_b_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic              special_s;
    logic [XLEN-1:0]   special_val_s;
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     div_shift_s;
    logic [XLEN-1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fin_val_s;

    assign sign_a_s = a_is_signed(funct3) & op_a[XLEN-1];
    assign sign_b_s = b_is_signed(funct3) & op_b[XLEN-1];

    mdu_sign_fix #(.W(XLEN)) u_mag_a (.val(op_a), .neg(sign_a_s), .res(mag_a_s));
    mdu_sign_fix #(.W(XLEN)) u_mag_b (.val(op_b), .neg(sign_b_s), .res(mag_b_s));

    mdu_sign_fix #(.W(2*XLEN)) u_fix_prod (.val(acc_r),                  .neg(neg_res_r), .res(prod_s));
    mdu_sign_fix #(.W(XLEN))   u_fix_quo  (.val(acc_r[XLEN-1:0]),        .neg(neg_res_r), .res(quo_s));
    mdu_sign_fix #(.W(XLEN))   u_fix_rem  (.val(acc_r[2*XLEN-1:XLEN]),   .neg(neg_rem_r), .res(rem_s));

    // detect operations whose result is known at issue and skip CALC
    always_comb begin
        special_s     = 1'b0;
        special_val_s = {XLEN{1'b0}};
        if (funct3[2] && (op_b == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? op_a : ALL_ONES;
        end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op_a == INT_MIN) && (op_b == ALL_ONES)) begin
            special_s     = 1'b1;
            special_val_s = funct3[1] ? {XLEN{1'b0}} : INT_MIN;
`ifdef MDU_FAST_ZERO_EN
        end else if ((op_a == {XLEN{1'b0}}) || (op_b == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_val_s = {XLEN{1'b0}};
`endif
        end else begin
            special_s     = 1'b0;
            special_val_s = {XLEN{1'b0}};
        end
    end

    // one shift-add (multiply) or restoring (divide) step on the accumulator
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                      (acc_r[0] ? {1'b0, div_r} : {(XLEN+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
        div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, div_r});
        div_diff_s  = div_shift_s[XLEN-1:0] - div_r;
        div_next_s  = {(div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0]),
                       acc_r[XLEN-2:0], div_ge_s};
        if (f3_r[2]) begin
            acc_next_s = div_next_s;
        end else begin
            acc_next_s = mul_next_s;
        end
    end

    // pick the signed-corrected word for the operation that just finished
    always_comb begin
        fin_val_s = {XLEN{1'b0}};
        if (special_r) begin
            fin_val_s = acc_r[XLEN-1:0];
        end else begin
            case (f3_r)
                F3_MUL:                       fin_val_s = prod_s[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: fin_val_s = prod_s[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              fin_val_s = quo_s;
                F3_REM, F3_REMU:              fin_val_s = rem_s;
                default:                      fin_val_s = {XLEN{1'b0}};
            endcase
        end
    end

    assign busy   = (state_r != S_IDLE);
    assign stall  = ((state_r == S_IDLE) & start & ~flush) | (state_r == S_CALC);
    // a flush during FIN suppresses the pulse and leaves the old result visible
    assign done   = (state_r == S_FIN) & ~flush;
    assign result = done ? fin_val_s : result_r;

    // FSM, iteration counter and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            f3_r      <= 3'b000;
            div_r     <= {XLEN{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            special_r <= 1'b0;
            result_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !flush) begin
                        f3_r      <= funct3;
                        div_r     <= mag_b_s;
                        neg_res_r <= sign_a_s ^ sign_b_s;
                        neg_rem_r <= sign_a_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        special_r <= special_s;
                        if (special_s) begin
                            acc_r   <= {{XLEN{1'b0}}, special_val_s};
                            state_r <= S_FIN;
                        end else begin
                            acc_r   <= {{XLEN{1'b0}}, mag_a_s};
                            state_r <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == CNT_LAST) begin
                            state_r <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    state_r <= S_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    if (!flush) begin
                        result_r <= fin_val_s;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: arithmetic results, latency,
// stall shape, special cases, flush, ignored start and asynchronous reset.
module tb_mdu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_fail;
    logic [31:0] last_res;

    mdu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // issue one op in the current cycle, optionally poke start while busy,
    // then track latency, stall cycles and the result
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input int poke_at);
        int lat;
        int stall_n;
        bit seen;
        @(negedge clk);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        #1;
        check_eq({tag, "_hold"}, 64'(result), 64'(last_res));
        check_eq({tag, "_stall0"}, 64'(stall), 64'd1);
        lat     = 0;
        stall_n = stall ? 1 : 0;
        seen    = 1'b0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            start = (lat == poke_at);
            if (lat == poke_at) funct3 = 3'b111;
            #1;
            if (done) seen = 1'b1;
            else if (stall) stall_n++;
        end
        start = 1'b0;
        check_eq({tag, "_done"}, 64'(seen), 64'd1);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, 64'(result), 64'(exp_res));
        check_eq({tag, "_stall_n"}, 64'(stall_n), 64'(exp_lat));
        check_eq({tag, "_stall_fin"}, 64'(stall), 64'd0);
        last_res = exp_res;
    endtask

    initial begin
        bit saw_done;
        n_checks = 0;
        n_fail   = 0;
        last_res = 32'h0000_0000;
        rst      = 1'b1;
        start    = 1'b0;
        funct3   = 3'b000;
        op_a     = 32'h0000_0000;
        op_b     = 32'h0000_0000;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_busy",   64'(busy),   64'd0);
        check_eq("rst_stall",  64'(stall),  64'd0);
        check_eq("rst_done",   64'(done),   64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        rst = 1'b0;

        run_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, -1);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, -1);
        run_op("mulh",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'h0000_0000, -1);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'h0000_0002, 33, 32'hFFFF_FFFF, -1);
        run_op("div",     3'b100, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD, -1);
        run_op("rem",     3'b110, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFF, -1);
        run_op("divu_z",  3'b101, 32'd5,          32'd0,         1,  32'hFFFF_FFFF, -1);
        run_op("remu_z",  3'b111, 32'd5,          32'd0,         1,  32'd5,         -1);
        run_op("div_ovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000, -1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h0000_0000, -1);
        run_op("divu",    3'b101, 32'd100,        32'd7,         33, 32'd14,        -1);

        // flush in the middle of CALC
        saw_done = 1'b0;
        @(negedge clk);
        funct3 = 3'b101;
        op_a   = 32'd100;
        op_b   = 32'd9;
        start  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
            #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_busy", 64'(busy),   64'd0);
        check_eq("flush_res",  64'(result), 64'(last_res));
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check_eq("flush_nodone", 64'(saw_done), 64'd0);

        run_op("divu_re", 3'b101, 32'd100, 32'd7, 33, 32'd14, -1);
        // back-to-back issue right after done, with a start poked while busy
        run_op("mul_poke", 3'b000, 32'd3, 32'd5, 33, 32'd15, 5);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd5;
        start  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check_eq("pre_rst_busy", 64'(busy), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("arst_busy",   64'(busy),   64'd0);
        check_eq("arst_stall",  64'(stall),  64'd0);
        check_eq("arst_done",   64'(done),   64'd0);
        check_eq("arst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        last_res = 32'h0000_0000;
        run_op("post_rst", 3'b011, 32'h0001_0000, 32'h0003_0000, 33, 32'd3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
